// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store unit: memory access-type codes,
// FSM state encoding and the request-type legality check.
package mem_access_unit_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic type_illegal(input logic [2:0] t);
    return (t == 3'b011) || (t == 3'b110) || (t == 3'b111);
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Picks the addressed byte/halfword out of a big-endian RAM word and
// sign- or zero-extends it to 32 bits according to the access type.
module mem_lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  pos_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    data_o = rdata_i;

    // Byte 0 of the word sits in the most significant lane.
    case (pos_i)
      2'b00:   byte_v = rdata_i[31:24];
      2'b01:   byte_v = rdata_i[23:16];
      2'b10:   byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = pos_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (type_i)
      MEM_B:   data_o = {{24{byte_v[7]}}, byte_v};
      MEM_BU:  data_o = {24'h000000, byte_v};
      MEM_H:   data_o = {{16{half_v[15]}}, half_v};
      MEM_HU:  data_o = {16'h0000, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data RAM: one request at a time,
// IDLE -> ACCESS -> RESP, with illegal requests answered without a RAM cycle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        ram_we,
  output logic [2:0]  ram_write_type,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  type_q, type_d;
  logic        ram_we_q, ram_we_d;
  logic [2:0]  ram_type_q, ram_type_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic        accept;
  logic        req_err;
  logic [31:0] lane_data;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_err = type_illegal(req_type)
                || (req_write && req_type[2])
                || ((req_type[1:0] == 2'b01) && req_addr[0])
                || ((req_type == MEM_W) && (req_addr[1:0] != 2'b00))
                || (req_addr[31:ADDR_W] != '0);

  mem_lane_extract u_lane (
    .rdata_i (ram_rdata),
    .pos_i   (ram_addr_q[1:0]),
    .type_i  (type_q),
    .data_o  (lane_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ram_we is only ever set on the IDLE->ACCESS edge, so it is clean for the level-sensitive RAM.
  always_comb begin
    write_d      = write_q;
    type_d       = type_q;
    ram_we_d     = 1'b0;
    ram_type_d   = ram_type_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          type_d  = req_type;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            ram_we_d   = req_write;
            ram_type_d = {1'b0, req_type[1:0]};
            ram_addr_d = req_addr;
            if (req_write) ram_wdata_d = req_wdata;
          end
        end
      end
      ST_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 32'h0 : lane_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q      <= 1'b0;
      type_q       <= MEM_W;
      ram_we_q     <= 1'b0;
      ram_type_q   <= MEM_W;
      ram_addr_q   <= 32'h0;
      ram_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      write_q      <= write_d;
      type_q       <= type_d;
      ram_we_q     <= ram_we_d;
      ram_type_q   <= ram_type_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign ram_we         = ram_we_q;
  assign ram_write_type = ram_type_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural big-endian word RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [2:0]  ram_write_type;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;

  logic [31:0] mem [0:1023] = '{default: 32'h0};

  mem_access_unit #(.ADDR_W(18)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_we(ram_we), .ram_write_type(ram_write_type), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: async read, byte/half/word write placed big-endian within the word.
  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_write_type)
        3'b000: case (ram_addr[1:0])
          2'b00: mem[ram_addr[11:2]][31:24] <= ram_wdata[7:0];
          2'b01: mem[ram_addr[11:2]][23:16] <= ram_wdata[7:0];
          2'b10: mem[ram_addr[11:2]][15:8]  <= ram_wdata[7:0];
          default: mem[ram_addr[11:2]][7:0] <= ram_wdata[7:0];
        endcase
        3'b001: if (ram_addr[1]) mem[ram_addr[11:2]][15:0] <= ram_wdata[15:0];
                else             mem[ram_addr[11:2]][31:16] <= ram_wdata[15:0];
        default: mem[ram_addr[11:2]] <= ram_wdata;
      endcase
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at #1 after a rising edge with the unit idle; returns at #1 after the edge that ends RESP.
  task automatic run_req(input string name, input logic w, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int we_hi;
    req_write = w; req_type = t; req_addr = a; req_wdata = d; req_valid = 1'b1;
    chk({name, ".ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    we_hi = ram_we ? 1 : 0;
    while (!resp_valid && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (ram_we) we_hi++;
    end
    chk({name, ".resp_seen"}, {31'h0, resp_valid}, 32'h1);
    chk({name, ".rdata"}, resp_rdata, exp_rd);
    chk({name, ".error"}, {31'h0, resp_error}, {31'h0, exp_err});
    chk({name, ".latency"}, n, exp_err ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    if (ram_we) we_hi++;
    chk({name, ".we_cycles"}, we_hi, (w && !exp_err) ? 32'd1 : 32'd0);
    chk({name, ".pulse_end"}, {30'h0, resp_valid, req_ready}, 32'h1);
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int last_acc;
    int resp0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_type = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;

    vecs.push_back('{"sw_10",    1'b1, 3'b010, 32'h10,    32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"lw_10",    1'b0, 3'b010, 32'h10,    32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"sw_20",    1'b1, 3'b010, 32'h20,    32'h11223380, 32'h0,        1'b0});
    vecs.push_back('{"lb_23",    1'b0, 3'b000, 32'h23,    32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"lbu_23",   1'b0, 3'b100, 32'h23,    32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{"lb_20",    1'b0, 3'b000, 32'h20,    32'h0,        32'h00000011, 1'b0});
    vecs.push_back('{"lh_22",    1'b0, 3'b001, 32'h22,    32'h0,        32'h00003380, 1'b0});
    vecs.push_back('{"lhu_20",   1'b0, 3'b101, 32'h20,    32'h0,        32'h00001122, 1'b0});
    vecs.push_back('{"sb_21",    1'b1, 3'b000, 32'h21,    32'h000000AA, 32'h0,        1'b0});
    vecs.push_back('{"lw_20a",   1'b0, 3'b010, 32'h20,    32'h0,        32'h11AA3380, 1'b0});
    vecs.push_back('{"sh_22",    1'b1, 3'b001, 32'h22,    32'h0000F00D, 32'h0,        1'b0});
    vecs.push_back('{"lh_22b",   1'b0, 3'b001, 32'h22,    32'h0,        32'hFFFFF00D, 1'b0});
    vecs.push_back('{"lhu_22",   1'b0, 3'b101, 32'h22,    32'h0,        32'h0000F00D, 1'b0});
    vecs.push_back('{"lb_21",    1'b0, 3'b000, 32'h21,    32'h0,        32'hFFFFFFAA, 1'b0});
    vecs.push_back('{"lbu_22",   1'b0, 3'b100, 32'h22,    32'h0,        32'h000000F0, 1'b0});
    vecs.push_back('{"lh_20",    1'b0, 3'b001, 32'h20,    32'h0,        32'h000011AA, 1'b0});
    vecs.push_back('{"sw_top",   1'b1, 3'b010, 32'h3FFFC, 32'h12345678, 32'h0,        1'b0});
    vecs.push_back('{"lw_top",   1'b0, 3'b010, 32'h3FFFC, 32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{"e_lw_22",  1'b0, 3'b010, 32'h22,    32'h0,        32'h0,        1'b1});
    vecs.push_back('{"e_lh_21",  1'b0, 3'b001, 32'h21,    32'h0,        32'h0,        1'b1});
    vecs.push_back('{"e_sbu",    1'b1, 3'b100, 32'h24,    32'h000000FF, 32'h0,        1'b1});
    vecs.push_back('{"e_shu",    1'b1, 3'b101, 32'h24,    32'h0000FFFF, 32'h0,        1'b1});
    vecs.push_back('{"e_range",  1'b0, 3'b010, 32'h40000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"e_sw_hi",  1'b1, 3'b010, 32'h80000024, 32'h55555555, 32'h0,     1'b1});
    vecs.push_back('{"e_t011",   1'b0, 3'b011, 32'h20,    32'h0,        32'h0,        1'b1});
    vecs.push_back('{"e_t110",   1'b0, 3'b110, 32'h20,    32'h0,        32'h0,        1'b1});
    vecs.push_back('{"e_t111",   1'b0, 3'b111, 32'h20,    32'h0,        32'h0,        1'b1});
    vecs.push_back('{"lw_24",    1'b0, 3'b010, 32'h24,    32'h0,        32'h0,        1'b0});
    vecs.push_back('{"lw_20b",   1'b0, 3'b010, 32'h20,    32'h0,        32'h11AAF00D, 1'b0});

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready",      {31'h0, req_ready},  32'h1);
    chk("rst.ram_we",     {31'h0, ram_we},     32'h0);
    chk("rst.ram_type",   {29'h0, ram_write_type}, 32'h2);
    chk("rst.ram_addr",   ram_addr,            32'h0);
    chk("rst.ram_wdata",  ram_wdata,           32'h0);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.resp_rdata", resp_rdata,          32'h0);
    chk("rst.resp_error", {31'h0, resp_error}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].w, vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].er, vecs[i].ee);

    // Reset in the middle of a store's ACCESS cycle
    req_write = 1'b1; req_type = 3'b010; req_addr = 32'h30; req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rst.we_before", {31'h0, ram_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst.we_after",  {31'h0, ram_we},     32'h0);
    chk("mid_rst.ready",     {31'h0, req_ready},  32'h1);
    chk("mid_rst.resp",      {31'h0, resp_valid}, 32'h0);
    resp0 = resp_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst.no_resp",   resp_cnt - resp0,    32'h0);
    chk("mid_rst.ready_rel", {31'h0, req_ready},  32'h1);
    run_req("mid_rst.lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0);
    run_req("mid_rst.lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // req_valid held high across six back-to-back loads
    resp0 = resp_cnt;
    acc = 0;
    last_acc = -1;
    req_write = 1'b0; req_type = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && acc < 6; cyc++) begin
      @(negedge clk);
      if (resp_valid) chk("b2b.rdata", resp_rdata, 32'hDEADBEEF);
      if (req_valid && req_ready) begin
        if (last_acc >= 0) chk("b2b.gap", cyc - last_acc, 32'd3);
        last_acc = cyc;
        acc++;
        if (acc == 6) begin
          @(posedge clk); #1;
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b.accepts", acc, 32'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) chk("b2b.rdata", resp_rdata, 32'hDEADBEEF);
    end
    chk("b2b.resp_count", resp_cnt - resp0, 32'd6);
    chk("b2b.idle", {31'h0, req_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
